// File: rtl/pong_io_frontend_if.sv
// Pong front-end bus: raw/clean keys toward the game logic and VGA timing
// toward the pixel renderer. The frontend takes the master modport and the
// consumer takes the slave modport. frame_tick is present only when
// FRAME_TICK_EN is defined.
interface pong_io_frontend_if;
  logic [3:0] KEY;
  logic [3:0] key_clean;
  logic       pix_en;
  logic       VGA_CLK;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       blank;
`ifdef FRAME_TICK_EN
  logic       frame_tick;
`endif

  modport master (
`ifdef FRAME_TICK_EN
    output frame_tick,
`endif
    input  KEY,
    output key_clean,
    output pix_en,
    output VGA_CLK,
    output x,
    output y,
    output hsync,
    output vsync,
    output blank
  );

  modport slave (
`ifdef FRAME_TICK_EN
    input  frame_tick,
`endif
    output KEY,
    input  key_clean,
    input  pix_en,
    input  VGA_CLK,
    input  x,
    input  y,
    input  hsync,
    input  vsync,
    input  blank
  );
endinterface

// File: rtl/pong_io_frontend.sv
// Pong display/input front end.
// - 640x480@60 VGA timing from CLOCK_50 using a divide-by-2 pixel enable.
// - Four independent debouncers for the active-low push buttons.
// Optional: define FRAME_TICK_EN to add the frame_tick strobe (one CLOCK_50
// cycle wide, on the cycle the counters become x=0, y=V_VISIBLE).
module pong_io_frontend #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int DEB_CYCLES = 500000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  pong_io_frontend_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_VISIBLE);
  localparam logic [9:0] V_ACT    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  // One extra bit so the counter can never wrap even at DEB_CYCLES-1.
  localparam int                DEB_W    = $clog2(DEB_CYCLES) + 1;
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Pixel enable
  // ---------------------------------------------------------------------
  logic r_t;

  // Divide-by-2 toggle; its high phase is the pixel enable.
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_t <= 1'b0;
    else       r_t <= ~r_t;
  end

  assign bus.pix_en  = r_t;
  assign bus.VGA_CLK = r_t;

  // ---------------------------------------------------------------------
  // Raster counters, sync and blank
  // ---------------------------------------------------------------------
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_blank;
  logic [9:0] w_x_next;
  logic [9:0] w_y_next;

  // Next raster position; holds between pixel enables.
  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    if (r_t) begin
      if (r_x == H_LAST) begin
        w_x_next = 10'd0;
        if (r_y == V_LAST) w_y_next = 10'd0;
        else               w_y_next = r_y + 10'd1;
      end else begin
        w_x_next = r_x + 10'd1;
      end
    end
  end

  // Sync/blank are decoded from the next position so they register together
  // with x/y and always describe the coordinates being presented.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_x     <= 10'd0;
      r_y     <= 10'd0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_blank <= 1'b0;
    end else if (r_t) begin
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_hsync <= !((w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST));
      r_vsync <= !((w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST));
      r_blank <= (w_x_next >= H_ACT) || (w_y_next >= V_ACT);
    end
  end

  assign bus.x     = r_x;
  assign bus.y     = r_y;
  assign bus.hsync = r_hsync;
  assign bus.vsync = r_vsync;
  assign bus.blank = r_blank;

`ifdef FRAME_TICK_EN
  localparam logic [9:0] V_ACT_LAST = 10'(V_VISIBLE - 1);

  logic r_frame_tick;

  // Pulse for the single cycle in which the counters step onto (0, V_VISIBLE).
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_frame_tick <= 1'b0;
    else       r_frame_tick <= r_t && (r_x == H_LAST) && (r_y == V_ACT_LAST);
  end

  assign bus.frame_tick = r_frame_tick;
`endif

  // ---------------------------------------------------------------------
  // Key debounce
  // ---------------------------------------------------------------------
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_key_clean;

  // Two-flop synchronizer; resets to "released" so no false press appears.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= bus.KEY;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_deb
    logic [DEB_W-1:0] r_cnt;
    logic             r_clean;

    // Count consecutive cycles the synchronized key disagrees with the clean
    // level; any agreement (a bounce back) restarts the count.
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        r_cnt   <= '0;
        r_clean <= 1'b1;
      end else if (r_sync2[g] == r_clean) begin
        r_cnt   <= '0;
      end else if (r_cnt == DEB_LAST) begin
        r_clean <= r_sync2[g];
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end

    assign w_key_clean[g] = r_clean;
  end

  assign bus.key_clean = w_key_clean;

endmodule

// File: tb/tb_pong_io_frontend.sv
// Bench for pong_io_frontend. Horizontal timing uses the real 800-pixel line;
// the vertical parameters are shrunk so a whole frame fits in a short run.
module tb_pong_io_frontend;
  localparam int DEB = 16;
  localparam int VV  = 12;
  localparam int VFP = 3;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int VT  = VV + VFP + VS + VBP;
  localparam int HT  = 800;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  pong_io_frontend_if u_if ();

  pong_io_frontend #(
    .H_VISIBLE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
    .V_VISIBLE (VV),  .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .DEB_CYCLES(DEB)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (u_if)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: edges since reset release, clean key levels,
  // run lengths of disagreement, and the raw KEY history.
  int         e = 0;
  logic [3:0] m_clean = 4'hF;
  int         m_run [4];
  logic [3:0] kq [$];

  typedef struct {
    int pix;
    int ex;
    int ey;
    bit hs;
    bit bl;
  } hvec_t;

  typedef struct {
    int key;
    int low1;
    int high1;
    int exp_lat;
  } dvec_t;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int p, mx, my;
    p  = e / 2;
    mx = p % HT;
    my = (p / HT) % VT;
    check("x", int'(u_if.x), mx);
    check("y", int'(u_if.y), my);
    check("hsync", int'(u_if.hsync), (mx >= 656 && mx <= 751) ? 0 : 1);
    check("vsync", int'(u_if.vsync), (my >= VV + VFP && my < VV + VFP + VS) ? 0 : 1);
    check("blank", int'(u_if.blank), (mx >= 640 || my >= VV) ? 1 : 0);
    check("pix_en", int'(u_if.pix_en), e % 2);
    check("VGA_CLK", int'(u_if.VGA_CLK), e % 2);
    check("key_clean", int'(u_if.key_clean), int'(m_clean));
`ifdef FRAME_TICK_EN
    check("frame_tick", int'(u_if.frame_tick),
          (e > 0 && e % 2 == 0 && mx == 0 && my == VV) ? 1 : 0);
`endif
  endtask

  // One CLOCK_50 cycle: update the model at the edge, compare at the negedge.
  task automatic step();
    logic [3:0] samp;
    @(posedge CLOCK_50);
    if (reset) begin
      e = 0;
      m_clean = 4'hF;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      kq.delete();
    end else begin
      e++;
      kq.push_back(u_if.KEY);
      samp = (kq.size() >= 3) ? kq[kq.size() - 3] : 4'hF;
      if (kq.size() > 3) void'(kq.pop_front());
      for (int i = 0; i < 4; i++) begin
        if (samp[i] == m_clean[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_clean[i] = samp[i];
            m_run[i]   = 0;
          end
        end
      end
    end
    @(negedge CLOCK_50);
    check_outputs();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hvec_t htab [9];
    dvec_t dtab [4];
    int    guard, n, cnt, hold [4];
    logic [3:0] kv;

    htab[0] = '{pix: 100, ex: 100, ey: 0, hs: 1, bl: 0};
    htab[1] = '{pix: 639, ex: 639, ey: 0, hs: 1, bl: 0};
    htab[2] = '{pix: 640, ex: 640, ey: 0, hs: 1, bl: 1};
    htab[3] = '{pix: 655, ex: 655, ey: 0, hs: 1, bl: 1};
    htab[4] = '{pix: 656, ex: 656, ey: 0, hs: 0, bl: 1};
    htab[5] = '{pix: 751, ex: 751, ey: 0, hs: 0, bl: 1};
    htab[6] = '{pix: 752, ex: 752, ey: 0, hs: 1, bl: 1};
    htab[7] = '{pix: 799, ex: 799, ey: 0, hs: 1, bl: 1};
    htab[8] = '{pix: 800, ex: 0,   ey: 1, hs: 1, bl: 0};

    dtab[0] = '{key: 2, low1: 0,  high1: 0, exp_lat: 18};
    dtab[1] = '{key: 0, low1: 10, high1: 3, exp_lat: 18};
    dtab[2] = '{key: 1, low1: 15, high1: 2, exp_lat: 18};
    dtab[3] = '{key: 3, low1: 5,  high1: 1, exp_lat: 18};

    for (int i = 0; i < 4; i++) m_run[i] = 0;
    u_if.KEY = 4'hF;
    reset    = 1'b1;
    @(negedge CLOCK_50);
    repeat (3) step();
    check("rst_x", int'(u_if.x), 0);
    check("rst_hsync", int'(u_if.hsync), 1);
    check("rst_key_clean", int'(u_if.key_clean), 15);
    reset = 1'b0;

    // pix_en pattern after release: first pulse, then every other cycle
    for (int i = 0; i < 6; i++) begin
      step();
      check("pix_en_seq", int'(u_if.pix_en), (i % 2 == 0) ? 1 : 0);
    end

    // Horizontal checkpoints
    for (int i = 0; i < 9; i++) begin
      guard = 0;
      while (e / 2 != htab[i].pix && guard < 4000) begin
        step();
        guard++;
      end
      check("h_reach", int'(e / 2 == htab[i].pix), 1);
      check("h_x", int'(u_if.x), htab[i].ex);
      check("h_y", int'(u_if.y), htab[i].ey);
      check("h_hsync", int'(u_if.hsync), int'(htab[i].hs));
      check("h_blank", int'(u_if.blank), int'(htab[i].bl));
    end

    // hsync width on line 1 measured in pixel enables
    cnt = 0;
    while (e / 2 < 2 * HT) begin
      step();
      if (u_if.pix_en && !u_if.hsync) cnt++;
    end
    check("hsync_width", cnt, 96);

    // Debounce vectors: optional bounce, then a held press and a release
    for (int i = 0; i < 4; i++) begin
      kv = u_if.KEY;
      if (dtab[i].low1 > 0) begin
        kv[dtab[i].key] = 1'b0;
        u_if.KEY = kv;
        repeat (dtab[i].low1) begin
          step();
          check("deb_bounce_low", int'(u_if.key_clean[dtab[i].key]), 1);
        end
        kv[dtab[i].key] = 1'b1;
        u_if.KEY = kv;
        repeat (dtab[i].high1) begin
          step();
          check("deb_bounce_high", int'(u_if.key_clean[dtab[i].key]), 1);
        end
      end
      kv[dtab[i].key] = 1'b0;
      u_if.KEY = kv;
      n = 0;
      do begin
        step();
        n++;
      end while (u_if.key_clean[dtab[i].key] != 1'b0 && n < 60);
      check("deb_fall_lat", n, dtab[i].exp_lat);
      check("deb_others", int'(u_if.key_clean | (4'b1 << dtab[i].key)), 15);
      kv[dtab[i].key] = 1'b1;
      u_if.KEY = kv;
      n = 0;
      do begin
        step();
        n++;
      end while (u_if.key_clean[dtab[i].key] != 1'b1 && n < 60);
      check("deb_rise_lat", n, dtab[i].exp_lat);
    end

    // One full frame with random key activity
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(40, 1);
    cnt = 0;
    n   = 0;
    for (int c = 0; c < 2 * HT * VT; c++) begin
      kv = u_if.KEY;
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          kv[i]   = ~kv[i];
          hold[i] = ($urandom_range(3, 0) == 0) ? $urandom_range(60, 20)
                                                : $urandom_range(12, 1);
        end
      end
      u_if.KEY = kv;
      step();
      if (!u_if.vsync) cnt++;
`ifdef FRAME_TICK_EN
      if (u_if.frame_tick) begin
        n++;
        check("ft_y", int'(u_if.y), VV);
        check("ft_x", int'(u_if.x), 0);
      end
`endif
    end
    check("vsync_cycles", cnt, 2 * HT * VS);
`ifdef FRAME_TICK_EN
    check("frame_tick_count", n, 1);
`endif

    // Mid-operation reset with key 1 held down
    u_if.KEY = 4'hD;
    repeat (25) step();
    check("pre_rst_key1", int'(u_if.key_clean[1]), 0);
    guard = 0;
    while (((e / 2) % (HT * VT)) != 5 * HT + 300 && guard < 40000) begin
      step();
      guard++;
    end
    check("pre_rst_x", int'(u_if.x), 300);
    check("pre_rst_y", int'(u_if.y), 5);
    reset = 1'b1;
    step();
    check("mid_rst_x", int'(u_if.x), 0);
    check("mid_rst_y", int'(u_if.y), 0);
    check("mid_rst_hsync", int'(u_if.hsync), 1);
    check("mid_rst_vsync", int'(u_if.vsync), 1);
    check("mid_rst_blank", int'(u_if.blank), 0);
    check("mid_rst_pix_en", int'(u_if.pix_en), 0);
    check("mid_rst_vga_clk", int'(u_if.VGA_CLK), 0);
    check("mid_rst_key_clean", int'(u_if.key_clean), 15);
    reset = 1'b0;
    repeat (30) step();
    check("post_rst_key1", int'(u_if.key_clean[1]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pong_io_frontend.md
Name: pong_io_frontend

Overview:
- Display/input front end of the Pong top level. Generates 640x480@60 Hz VGA timing from a single 50 MHz clock using an internal divide-by-2 pixel enable.
- Also debounces the four active-low push buttons into clean, glitch-free levels.
- Outputs feed the pixel renderer (x/y/blank) and the paddle movement logic (clean keys).

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- DEB_CYCLES, 500000, consecutive stable clock cycles required before a key output changes (10 ms at 50 MHz)

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; only clock in the block
- reset  in  1  synchronous, active-high reset
- KEY  in  4  raw push buttons, active-low, asynchronous to CLOCK_50
- key_clean  out  4  debounced KEY, active-low (1 = released)
- pix_en  out  1  pixel-clock enable, high every other CLOCK_50 cycle
- VGA_CLK  out  1  25 MHz pixel clock; equals the divide-by-2 toggle flop
- x  out  10  current pixel column, 0..799
- y  out  10  current line, 0..524
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- blank  out  1  high outside the 640x480 visible area

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on the CLOCK_50 rising edge. All state is registered.
- Reset values:
  - x=0, y=0, hsync=1, vsync=1, blank=0, pix_en=0, VGA_CLK=0.
  - key_clean=4'b1111.
  - Debounce counters 0; synchronizer flops 1.
- Pixel enable:
  - Toggle flop t; VGA_CLK=t.
  - pix_en asserts on the cycle where t is 1. First pix_en is on the 2nd cycle after reset deasserts, then every 2 cycles.
- Counters advance only when pix_en=1:
  - x increments; when x = H_total-1 (799), x wraps to 0 and y increments.
  - When y = V_total-1 (524) and x wraps, y wraps to 0.
  - Totals are the sum of their four parameters: 800 and 525.
- Sync and blank are registered and updated in the same cycle as x/y, so they are aligned with the x/y values currently presented (zero relative latency):
  - hsync=0 iff 656 <= x <= 751.
  - vsync=0 iff 490 <= y <= 491.
  - blank=1 iff x >= 640 or y >= 480.
- Between pix_en pulses, x, y, hsync, vsync and blank hold their values.
- Frame period is 420000 pix_en pulses (840000 CLOCK_50 cycles).
- Debounce (per key, 4 independent identical channels):
  - 2-flop synchronizer on KEY[i] produces s.
  - If s == key_clean[i], the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEB_CYCLES-1 while s still differs, key_clean[i] <= s and the counter clears.
  - Output change latency is 2 + DEB_CYCLES cycles from a stable input edge.
  - Any bounce (s returning to key_clean[i]) before the threshold restarts the count from 0.
  - The counter is wide enough for DEB_CYCLES, i.e. $clog2(DEB_CYCLES)+1 bits; it never wraps.
- Simultaneous key events are handled independently per channel.
- Reset asserted mid-frame or mid-debounce returns everything to its reset values on the next edge.

Optional Feature:
- Macro FRAME_TICK_EN.
- Defined:
  - Adds output frame_tick (1 bit, reset 0).
  - frame_tick is a one-CLOCK_50-cycle pulse on the cycle the counters become x=0, y=480 (start of vertical blanking).
  - The renderer/game logic uses it as its once-per-frame update strobe.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset/enable:
  - Hold reset 3 cycles, release.
  - x=0, y=0, blank=0, hsync=vsync=1, key_clean=1111.
  - pix_en high on release-cycle+2, then every 2 cycles.
- Horizontal timing: run 1600 CLOCK_50 cycles.
  - x reaches 799 then 0; y becomes 1.
  - hsync low for exactly 96 pix_en pulses starting at x=656.
  - blank rises at x=640.
- Vertical timing: run one full frame (840000 cycles).
  - vsync low only on y=490 and y=491.
  - blank high for all of y=480..524.
  - y wraps to 0 after line 524, x=799.
- Debounce clean press (DEB_CYCLES=16):
  - KEY[2] 1->0 and held.
  - key_clean[2] falls exactly 18 cycles after the edge; other bits stay 1.
- Debounce bounce (DEB_CYCLES=16):
  - KEY[0] low 10 cycles, high 3 cycles, then low and held.
  - No output change during the bounce.
  - key_clean[0] falls 18 cycles after the final falling edge.
- Mid-operation reset plus FRAME_TICK_EN:
  - Assert reset at x=300, y=200 with key_clean[1]=0. Outputs return to reset values next cycle.
  - With FRAME_TICK_EN defined, exactly one frame_tick per 840000 cycles, coinciding with y=480, x=0.
